// File: rtl/counter_xn.sv
// counter_xn: N independent WIDTH-bit counter channels behind the MIO counter slot.
// Each channel counts rising edges of its own divider tick in one of four modes
// (one-shot, periodic, square wave, free-run). Channel index N on the bus is the
// packed control word (3 bits per channel: {gate, mode[1:0]}).
// Optional feature: define COUNTER_XN_IRQ_EN to add sticky per-channel interrupt
// pending bits (irq_pend) with write-1-to-clear acknowledge (irq_ack).

// Single counter channel: reload/count registers plus output line and one-shot done flag.
module counter_xn_ch #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ev_i,        // tick rising edge this cycle
    input  logic             wr_i,        // bus write to this channel
    input  logic [WIDTH-1:0] wr_val_i,
    input  logic [1:0]       mode_i,      // current (pre-write) mode
    input  logic             gate_i,
    input  logic             mode_chg_i,  // control write changes this channel's mode
    output logic [WIDTH-1:0] count_o,
    output logic             out_o,
    output logic             term_o       // terminal / wrap event taken this cycle
);
    typedef enum logic [1:0] {
        M_ONESHOT  = 2'b00,
        M_PERIODIC = 2'b01,
        M_SQUARE   = 2'b10,
        M_FREERUN  = 2'b11
    } mode_e;

    mode_e            mode;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             out_q, out_d;
    logic             done_q, done_d;

    assign mode    = mode_e'(mode_i);
    assign count_o = count_q;
    assign out_o   = out_q;

    // Next state: bus write beats a mode change, which beats a count event.
    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        out_d    = out_q;
        done_d   = done_q;
        term_o   = 1'b0;
        // Pulse modes hold OUT high for a single clk only.
        if (mode == M_PERIODIC || mode == M_FREERUN) begin
            out_d = 1'b0;
        end
        if (wr_i) begin
            reload_d = wr_val_i;
            count_d  = wr_val_i;
            out_d    = 1'b0;
            done_d   = 1'b0;
        end else if (mode_chg_i) begin
            count_d = reload_q;
            out_d   = 1'b0;
            done_d  = 1'b0;
        end else if (ev_i && gate_i && !done_q) begin
            unique case (mode)
                M_ONESHOT: begin
                    if (count_q == '0) begin
                        out_d  = 1'b1;
                        done_d = 1'b1;
                        term_o = 1'b1;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
                M_PERIODIC: begin
                    if (count_q == '0) begin
                        count_d = reload_q;
                        out_d   = 1'b1;
                        term_o  = 1'b1;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
                M_SQUARE: begin
                    if (count_q == '0) begin
                        count_d = reload_q;
                        out_d   = ~out_q;
                        term_o  = 1'b1;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
                M_FREERUN: begin
                    count_d = count_q + WIDTH'(1);
                    if (count_q == '1) begin
                        out_d  = 1'b1;
                        term_o = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            reload_q <= '0;
            out_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            out_q    <= out_d;
            done_q   <= done_d;
        end
    end
endmodule

module counter_xn #(
    parameter int N     = 3,
    parameter int WIDTH = 32,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     tick,
    input  logic             counter_we,
    input  logic [SEL_W-1:0] counter_ch,
    input  logic [31:0]      counter_val,
    output logic [N-1:0]     counter_OUT,
`ifdef COUNTER_XN_IRQ_EN
    output logic [N-1:0]     irq_pend,
    input  logic [N-1:0]     irq_ack,
`endif
    output logic [31:0]      counter_out
);
    localparam int CW = 3 * N;

    if (N < 1 || N > 10 || WIDTH < 1 || WIDTH > 32 || (1 << SEL_W) <= N) begin : g_bad_param
        $error("counter_xn: illegal parameter set");
    end

    logic [N-1:0]            tick_q;
    logic [N-1:0]            ev;
    logic [N-1:0]            wr;
    logic [N-1:0]            mode_chg;
    logic [N-1:0]            term;
    logic [N-1:0][WIDTH-1:0] cnt;
    logic [CW-1:0]           ctrl_q, ctrl_d;
    logic                    ctrl_wr;
    logic                    unused_val;

    // Upper data bits are unused for narrow channel/control configurations.
    assign unused_val = ^counter_val;

    assign ev      = tick & ~tick_q;
    assign ctrl_wr = counter_we && (counter_ch == SEL_W'(N));

    // Control word next state.
    always_comb begin
        ctrl_d = ctrl_q;
        if (ctrl_wr) begin
            ctrl_d = counter_val[CW-1:0];
        end
    end

    // Tick history keeps tracking during reset so a level held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= tick;
            ctrl_q <= '0;
        end else begin
            tick_q <= tick;
            ctrl_q <= ctrl_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_ch
        assign wr[g]       = counter_we && (counter_ch == SEL_W'(g));
        assign mode_chg[g] = ctrl_wr && (counter_val[3*g +: 2] != ctrl_q[3*g +: 2]);

        counter_xn_ch #(.WIDTH(WIDTH)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .ev_i       (ev[g]),
            .wr_i       (wr[g]),
            .wr_val_i   (counter_val[WIDTH-1:0]),
            .mode_i     (ctrl_q[3*g +: 2]),
            .gate_i     (ctrl_q[3*g+2]),
            .mode_chg_i (mode_chg[g]),
            .count_o    (cnt[g]),
            .out_o      (counter_OUT[g]),
            .term_o     (term[g])
        );
    end

`ifdef COUNTER_XN_IRQ_EN
    logic [N-1:0] irq_q, irq_d;

    // Sticky pending: a new terminal event beats a same-cycle ack; a channel write clears.
    always_comb begin
        irq_d = ((irq_q & ~irq_ack) | term) & ~wr;
    end

    // Pending register.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_pend = irq_q;
`else
    logic unused_term;
    assign unused_term = ^term;
`endif

    // Bus readback: channel count zero-extended, or the control word at index N.
    always_comb begin
        counter_out = '0;
        for (int i = 0; i < N; i++) begin
            if (counter_ch == SEL_W'(i)) begin
                counter_out = 32'(cnt[i]);
            end
        end
        if (counter_ch == SEL_W'(N)) begin
            counter_out = 32'(ctrl_q);
        end
    end
endmodule
